rr_mux_reg: RTL and testbench

//  N-input, WIDTH-bit registered selector with valid/ready handshakes and round-robin arbitration.

---
 rtl/rr_mux_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 49 ++++
 rtl/rr_mux_reg.sv | 108 ++++++++++
 tb/tb_rr_mux_reg.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// Shared defaults and the round-robin pointer helper for rr_mux_reg and rr_arbiter.
package rr_mux_pkg;

    localparam int unsigned RR_MUX_WIDTH_DEF = 64;
    localparam int unsigned RR_MUX_N_DEF     = 4;

    // A grant index g >= n stands for "no grant"; the pointer then holds.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned g,
                                            input int unsigned n);
        if (g >= n) begin
            return ptr;
        end
        return (g == n - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority search starting at the registered pointer, plus the pointer flop.
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter  int unsigned N    = RR_MUX_N_DEF,
    localparam int unsigned SELW = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         adv,
    output logic [N-1:0] grant
);

    logic [SELW-1:0] r_ptr;
    int unsigned     w_gidx;

    always_comb begin
        logic            found;
        logic [SELW-1:0] idx;
        int unsigned     sum;
        found  = 1'b0;
        idx    = '0;
        sum    = 0;
        grant  = '0;
        w_gidx = N;
        for (int unsigned k = 0; k < N; k++) begin
            sum = 32'(r_ptr) + k;
            if (sum >= N) begin
                sum = sum - N;
            end
            idx = SELW'(sum);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                w_gidx     = sum;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (adv) begin
            r_ptr <= SELW'(rr_next(32'(r_ptr), w_gidx, N));
        end
    end

endmodule

// File: rtl/rr_mux_reg.sv
// N-input registered round-robin selector with valid/ready handshakes.
// Define RR_MUX_SKID_EN to add a 1-entry skid so in_ready no longer depends on out_ready.
module rr_mux_reg
    import rr_mux_pkg::*;
#(
    parameter  int unsigned WIDTH = RR_MUX_WIDTH_DEF,
    parameter  int unsigned N     = RR_MUX_N_DEF,
    localparam int unsigned SELW  = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SELW-1:0]  out_sel
);

    typedef struct packed {
        logic             valid;
        logic [SELW-1:0]  sel;
        logic [WIDTH-1:0] data;
    } out_stage_t;

    out_stage_t       r_out;
    logic [N-1:0]     w_grant;
    logic [WIDTH-1:0] w_mux_data;
    logic [SELW-1:0]  w_mux_sel;
    logic             w_load;
    logic             w_xfer;

    rr_arbiter #(
        .N (N)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (in_valid),
        .adv   (w_xfer),
        .grant (w_grant)
    );

    always_comb begin
        w_mux_data = '0;
        w_mux_sel  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_mux_data = w_mux_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
            if (w_grant[i]) begin
                w_mux_sel = w_mux_sel | SELW'(i);
            end
        end
    end

    assign w_load = !r_out.valid || out_ready;

`ifdef RR_MUX_SKID_EN
    logic             r_skid_full;
    logic [SELW-1:0]  r_skid_sel;
    logic [WIDTH-1:0] r_skid_data;

    // Ready comes from the skid flag only; out_ready reaches nothing on the input side.
    assign in_ready = (reset || r_skid_full) ? '0 : w_grant;
    assign w_xfer   = !reset && !r_skid_full && (|w_grant);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out       <= '0;
            r_skid_full <= 1'b0;
            r_skid_sel  <= '0;
            r_skid_data <= '0;
        end else if (w_load) begin
            if (r_skid_full) begin
                r_out       <= '{valid: 1'b1, sel: r_skid_sel, data: r_skid_data};
                r_skid_full <= 1'b0;
            end else if (w_xfer) begin
                r_out <= '{valid: 1'b1, sel: w_mux_sel, data: w_mux_data};
            end else begin
                r_out.valid <= 1'b0;
            end
        end else if (w_xfer) begin
            r_skid_sel  <= w_mux_sel;
            r_skid_data <= w_mux_data;
            r_skid_full <= 1'b1;
        end
    end
`else
    assign in_ready = (reset || !w_load) ? '0 : w_grant;
    assign w_xfer   = !reset && w_load && (|w_grant);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out <= '0;
        end else if (w_load) begin
            if (w_xfer) begin
                r_out <= '{valid: 1'b1, sel: w_mux_sel, data: w_mux_data};
            end else begin
                r_out.valid <= 1'b0;
            end
        end
    end
`endif

    assign out_valid = r_out.valid;
    assign out_data  = r_out.data;
    assign out_sel   = r_out.sel;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Self-checking bench for rr_mux_reg against a queue-based round-robin model.
`timescale 1ns/1ps
module tb_rr_mux_reg;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned N     = 4;
    localparam int unsigned SELW  = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [N*WIDTH-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_sel;

    rr_mux_reg #(
        .WIDTH (WIDTH),
        .N     (N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SELW-1:0]  sel;
        logic [WIDTH-1:0] data;
    } beat_t;

    // Model: beats held inside the block (output register first), oldest at the head.
    beat_t            m_q[$];
    int               m_ptr;
    logic [WIDTH-1:0] m_last_data;
    logic [SELW-1:0]  m_last_sel;
    bit               pend[N];
    logic [WIDTH-1:0] src_data[N];
    int               n_checks = 0;
    int               n_errors = 0;
    logic [N+WIDTH+SELW:0] v_act, v_exp;

    function automatic int exp_grant();
        int c;
        for (int k = 0; k < int'(N); k++) begin
            c = (m_ptr + k) % int'(N);
            if (pend[c]) return c;
        end
        return -1;
    endfunction

    function automatic bit can_accept();
`ifdef RR_MUX_SKID_EN
        return m_q.size() < 2;
`else
        return (m_q.size() == 0) || (out_ready == 1'b1);
`endif
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        g = exp_grant();
        if (g >= 0 && can_accept()) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic exp_valid();
        return m_q.size() > 0;
    endfunction

    function automatic logic [WIDTH-1:0] exp_data();
        return (m_q.size() > 0) ? m_q[0].data : m_last_data;
    endfunction

    function automatic logic [SELW-1:0] exp_sel();
        return (m_q.size() > 0) ? m_q[0].sel : m_last_sel;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ptr       = 0;
        m_last_data = '0;
        m_last_sel  = '0;
    endtask

    // Sources raise valid when they want to send and hold it until accepted.
    task automatic drive(input logic [N-1:0] want, input logic ordy, input bit cst);
        for (int i = 0; i < int'(N); i++) begin
            if (!pend[i] && want[i]) begin
                pend[i]     = 1'b1;
                src_data[i] = cst ? (64'hDEAD_BEEF_0000_0000 | 64'(i)) : {$urandom(), $urandom()};
            end
            in_valid[i]                = pend[i];
            in_data[i*WIDTH +: WIDTH]  = src_data[i];
        end
        out_ready = ordy;
        v_act = {in_ready, out_valid, out_data, out_sel};
    endtask

    task automatic advance();
        int    g;
        bit    acc;
        beat_t b;
        g   = exp_grant();
        acc = (g >= 0) && can_accept();
        if (out_ready && m_q.size() > 0) begin
            b           = m_q.pop_front();
            m_last_data = b.data;
            m_last_sel  = b.sel;
        end
        if (acc) begin
            b.sel  = SELW'(g);
            b.data = src_data[g];
            m_q.push_back(b);
            m_ptr   = (g + 1) % int'(N);
            pend[g] = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = '0;
        out_ready = 1'b0;
        for (int i = 0; i < int'(N); i++) pend[i] = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(4'hF, (k == 0), 1'b0);
            #1;
            v_act = {in_ready, out_valid, out_data, out_sel};
            v_exp = {exp_ready(), exp_valid(), exp_data(), exp_sel()};
            n_checks++;
            if (v_act !== v_exp) begin
                n_errors++;
                $display("FAIL reset_prefill k=%0d: got %h want %h", k, v_act, v_exp);
            end
            advance();
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, out_data, out_sel} !== '0) begin
            n_errors++;
            $display("FAIL reset_async_out: got v=%b d=%h s=%0d want zeros",
                     out_valid, out_data, out_sel);
        end
        n_checks++;
        if (in_ready !== '0) begin
            n_errors++;
            $display("FAIL reset_in_ready: got %b want 0000", in_ready);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(4'hF, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (in_ready !== 4'b0001) begin
            n_errors++;
            $display("FAIL reset_ptr_zero: got %b want 0001", in_ready);
        end
        advance();
    endtask

    task automatic test_single();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(4'b0100, 1'b1, 1'b1);
            #1;
            n_checks++;
            if (in_ready !== 4'b0100) begin
                n_errors++;
                $display("FAIL single_ready k=%0d: got %b want 0100", k, in_ready);
            end
            if (k > 0) begin
                n_checks++;
                if ({out_valid, out_sel, out_data} !== {1'b1, 2'd2, 64'hDEAD_BEEF_0000_0002}) begin
                    n_errors++;
                    $display("FAIL single_out k=%0d: got v=%b s=%0d d=%h want v=1 s=2 d=deadbeef00000002",
                             k, out_valid, out_sel, out_data);
                end
            end
            advance();
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(4'hF, 1'b1, 1'b0);
            #1;
            n_checks++;
            if (in_ready !== 4'(1 << (k % 4))) begin
                n_errors++;
                $display("FAIL rr_grant k=%0d: got %b want %b", k, in_ready, 4'(1 << (k % 4)));
            end
            v_act = {in_ready, out_valid, out_data, out_sel};
            v_exp = {exp_ready(), exp_valid(), exp_data(), exp_sel()};
            n_checks++;
            if (v_act !== v_exp) begin
                n_errors++;
                $display("FAIL rr_model k=%0d: got %h want %h", k, v_act, v_exp);
            end
            if (k > 0) begin
                n_checks++;
                if (out_sel !== SELW'((k - 1) % 4)) begin
                    n_errors++;
                    $display("FAIL rr_out_sel k=%0d: got %0d want %0d", k, out_sel, (k - 1) % 4);
                end
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 0; k < 7; k++) begin
            drive(4'hF, !(k >= 1 && k <= 3), 1'b0);
            #1;
            v_act = {in_ready, out_valid, out_data, out_sel};
            v_exp = {exp_ready(), exp_valid(), exp_data(), exp_sel()};
            n_checks++;
            if (v_act !== v_exp) begin
                n_errors++;
                $display("FAIL bp_model k=%0d: got %h want %h", k, v_act, v_exp);
            end
            if (k >= 1 && k <= 3) begin
                n_checks++;
                if ({out_valid, out_sel} !== {1'b1, 2'd0}) begin
                    n_errors++;
                    $display("FAIL bp_hold k=%0d: got v=%b s=%0d want v=1 s=0", k, out_valid, out_sel);
                end
            end
`ifndef RR_MUX_SKID_EN
            if (k >= 1 && k <= 4) begin
                n_checks++;
                if (in_ready !== ((k == 4) ? 4'b0010 : 4'b0000)) begin
                    n_errors++;
                    $display("FAIL bp_ready k=%0d: got %b want %b", k, in_ready,
                             (k == 4) ? 4'b0010 : 4'b0000);
                end
            end
`endif
            advance();
        end
    endtask

    task automatic test_wrap_sparse();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive((k < 3) ? 4'b0111 : 4'b0011, 1'b1, 1'b0);
            #1;
            v_act = {in_ready, out_valid, out_data, out_sel};
            v_exp = {exp_ready(), exp_valid(), exp_data(), exp_sel()};
            n_checks++;
            if (v_act !== v_exp) begin
                n_errors++;
                $display("FAIL wrap_model k=%0d: got %h want %h", k, v_act, v_exp);
            end
            if (k >= 3) begin
                n_checks++;
                if (in_ready !== ((k == 3) ? 4'b0001 : 4'b0010)) begin
                    n_errors++;
                    $display("FAIL wrap_grant k=%0d: got %b want %b", k, in_ready,
                             (k == 3) ? 4'b0001 : 4'b0010);
                end
            end
            advance();
        end
    endtask

    task automatic test_toggle_ready();
        logic [7:0]      rdy_seq;
        logic [N-1:0]    e;
        logic [SELW-1:0] obs[$];
        rdy_seq = 8'b1111_1001;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(4'hF, rdy_seq[k], 1'b0);
            #1;
            v_act = {in_ready, out_valid, out_data, out_sel};
            v_exp = {exp_ready(), exp_valid(), exp_data(), exp_sel()};
            n_checks++;
            if (v_act !== v_exp) begin
                n_errors++;
                $display("FAIL toggle_model k=%0d: got %h want %h", k, v_act, v_exp);
            end
            if (out_valid && out_ready) obs.push_back(out_sel);
`ifdef RR_MUX_SKID_EN
            e = exp_ready();
            out_ready = !rdy_seq[k];
            #1;
            n_checks++;
            if (in_ready !== e) begin
                n_errors++;
                $display("FAIL toggle_comb_path k=%0d: got %b want %b", k, in_ready, e);
            end
            out_ready = rdy_seq[k];
            #1;
`else
            e = '0;
`endif
            advance();
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (k >= obs.size()) begin
                n_errors++;
                $display("FAIL toggle_order k=%0d: got no beat want sel %0d", k, k);
            end else if (obs[k] !== SELW'(k)) begin
                n_errors++;
                $display("FAIL toggle_order k=%0d: got %0d want %0d", k, obs[k], k);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            drive(4'($urandom()), ($urandom_range(0, 3) != 0), 1'b0);
            #1;
            v_act = {in_ready, out_valid, out_data, out_sel};
            v_exp = {exp_ready(), exp_valid(), exp_data(), exp_sel()};
            n_checks++;
            if (v_act !== v_exp) begin
                n_errors++;
                $display("FAIL random_model k=%0d: got %h want %h", k, v_act, v_exp);
            end
            advance();
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            pend[i]     = 1'b0;
            src_data[i] = '0;
        end
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap_sparse();
        test_toggle_ready();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
